rs_enc_ctrl: RTL
================

RS_ENC_CTRL -- requirements
Module: rs_enc_ctrl

Interface
REQ-001 SHALL have parameter K, default 239: message symbols per codeword, legal range 1..253.
REQ-002 SHALL have parameter NPAR, default 16: parity symbols per codeword, legal range 2..16, with K+NPAR <= 255.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_data  input  8  message symbol.
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_sop  input  1  first symbol of a message; qualified by in_valid.
REQ-008 SHALL have port in_ready  output  1  controller accepts a symbol this cycle.
REQ-009 SHALL have port out_data  output  8  codeword symbol.
REQ-010 SHALL have port out_valid  output  1  out_data valid.
REQ-011 SHALL have port out_sop  output  1  first codeword symbol.
REQ-012 SHALL have port out_eop  output  1  last codeword symbol.
REQ-013 SHALL have port out_ready  input  1  downstream accepts a symbol.
REQ-014 SHALL have port enc_en  output  1  advance the parity LFSR stages this cycle.
REQ-015 SHALL have port enc_clr  output  1  synchronous clear of all LFSR stages.
REQ-016 SHALL have port fb_gate  output  1  1 = feedback is (in_data ^ par_in); 0 = feedback forced to zero, so the LFSR shifts parity out.
REQ-017 SHALL have port enc_sym  output  8  symbol presented to the LFSR input (in_data in MSG, 0 otherwise).
REQ-018 SHALL have port par_in  input  8  last LFSR stage, the highest-order parity register.
REQ-019 SHALL have port err  output  1  one-cycle protocol-error pulse.

Function
REQ-020 SHALL implement the FSM states IDLE, MSG and PAR; the reset state is IDLE.
REQ-021 In IDLE: in_ready=1; a symbol with in_valid&in_sop and out_ready=1 SHALL be accepted, forwarded with out_sop=1, and moved to MSG with sym_cnt=1.
REQ-022 In IDLE: in_valid without in_sop SHALL be consumed (in_ready=1), dropped, and SHALL pulse err.
REQ-023 In MSG: in_ready=out_ready; on a transfer (in_valid&in_ready) out_data=in_data, out_valid=1, enc_en=1, fb_gate=1, and sym_cnt increments.
REQ-024 In MSG: the transfer with sym_cnt==K-1 SHALL move the FSM to PAR with par_cnt=0.
REQ-025 In PAR: in_ready=0, out_data=par_in, out_valid=1, fb_gate=0, enc_en=out_ready.
REQ-026 In PAR: par_cnt increments on each out_ready; the symbol with par_cnt==NPAR-1 SHALL carry out_eop=1 and return the FSM to IDLE.
REQ-027 enc_clr SHALL be asserted in the same cycle as every accepted in_sop symbol, so the LFSR starts from zero; the datapath gives clear priority and loads the first symbol's feedback.
REQ-028 Backpressure: when out_ready=0, enc_en=0 and all counters and FSM state SHALL hold; out_data/out_valid are combinational from the current state and inputs.
REQ-029 An in_sop accepted while in MSG SHALL pulse err, abort the current frame without emitting parity, and restart MSG with sym_cnt=1 and enc_clr=1.
REQ-030 The codeword SHALL be K+NPAR symbols, with exactly one out_sop and one out_eop; sym_cnt and par_cnt SHALL be 8 bits and never wrap.
REQ-031 Controller latency from input to output SHALL be zero cycles; parity is valid on par_in one cycle after the last message transfer.

Reset
REQ-032 While rst=1: state=IDLE, sym_cnt=0, par_cnt=0, out_valid=0, out_sop=0, out_eop=0, enc_en=0, fb_gate=0, enc_clr=0, enc_sym=0, err=0, out_data=0, in_ready=0.
REQ-033 A reset asserted mid-frame SHALL discard the frame; after release the controller waits for a new in_sop with in_ready=1.

Verification
REQ-034 K=4, NPAR=2, continuous valid, out_ready=1, message 01,02,03,04 -> 6 output symbols; sop on symbol 0, eop on symbol 5; enc_en high for 6 cycles; fb_gate high for exactly 4 cycles.
REQ-035 Default K/NPAR against a golden RS(255,239) model on random messages -> 255 symbols matching the model; parity symbols are taken from par_in.
REQ-036 out_ready low for 3 cycles during MSG and for 2 cycles during PAR -> no symbol lost or duplicated; enc_en=0 and counters frozen during the stalls.
REQ-037 in_valid without sop in IDLE -> err pulses once and no output; a second in_sop at message symbol 2 -> err pulses, enc_clr=1, and the new frame completes normally.
REQ-038 rst asserted at parity symbol 1 -> all outputs 0 immediately; the next frame after release encodes correctly.

Source files
------------

// File: rtl/rs_enc_ctrl.sv
// rs_enc_ctrl: sequences message and parity symbols of a systematic RS(K+NPAR,K) encoder
// around an external parity LFSR, with zero-latency pass-through and backpressure.
module rs_enc_ctrl #(
    parameter int K    = 239,
    parameter int NPAR = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_sop,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_sop,
    output logic       out_eop,
    input  logic       out_ready,
    output logic       enc_en,
    output logic       enc_clr,
    output logic       fb_gate,
    output logic [7:0] enc_sym,
    input  logic [7:0] par_in,
    output logic       err
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MSG  = 2'd1;
    localparam logic [1:0] PAR  = 2'd2;
    localparam logic [7:0] K_LAST = 8'(K - 1);
    localparam logic [7:0] P_LAST = 8'(NPAR - 1);
    localparam logic [1:0] AFTER_SOP = (K == 1) ? PAR : MSG;

    logic [1:0] state, state_nx;
    logic [7:0] sym_cnt, sym_nx, par_cnt, par_nx;
    logic       sop_in, take;

    assign sop_in = in_valid & in_sop;

    always_comb begin
        state_nx  = state;
        sym_nx    = sym_cnt;
        par_nx    = par_cnt;
        in_ready  = 1'b0;
        out_data  = 8'd0;
        out_valid = 1'b0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        enc_en    = 1'b0;
        enc_clr   = 1'b0;
        fb_gate   = 1'b0;
        enc_sym   = 8'd0;
        err       = 1'b0;
        take      = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    // A stalled sop is held upstream rather than consumed; stray data is dropped.
                    in_ready  = out_ready | ~sop_in;
                    out_valid = sop_in;
                    out_sop   = sop_in;
                    out_data  = sop_in ? in_data : 8'd0;
                    err       = in_valid & ~in_sop;
                    take      = sop_in & out_ready;
                end
                MSG: begin
                    in_ready  = out_ready;
                    out_valid = in_valid;
                    out_sop   = sop_in;
                    out_data  = in_data;
                    enc_sym   = in_data;
                    take      = in_valid & out_ready;
                    err       = take & in_sop;
                end
                PAR: begin
                    out_valid = 1'b1;
                    out_data  = par_in;
                    out_eop   = (par_cnt == P_LAST);
                    enc_en    = out_ready;
                    if (out_ready) begin
                        par_nx   = (par_cnt == P_LAST) ? 8'd0 : par_cnt + 8'd1;
                        sym_nx   = (par_cnt == P_LAST) ? 8'd0 : sym_cnt;
                        state_nx = (par_cnt == P_LAST) ? IDLE : PAR;
                    end
                end
                default: state_nx = IDLE;
            endcase
            if (take) begin
                enc_en  = 1'b1;
                fb_gate = 1'b1;
                enc_sym = in_data;
                enc_clr = in_sop;
                par_nx  = 8'd0;
                // A fresh sop (from IDLE or aborting a frame) restarts the count at one.
                sym_nx   = in_sop ? 8'd1 : sym_cnt + 8'd1;
                state_nx = in_sop ? AFTER_SOP : ((sym_cnt == K_LAST) ? PAR : MSG);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sym_cnt <= 8'd0;
            par_cnt <= 8'd0;
        end else begin
            state   <= state_nx;
            sym_cnt <= sym_nx;
            par_cnt <= par_nx;
        end
    end
endmodule
